// File: rtl/mdu_iter_if.sv
// Handshake/operand bundle between issue logic and the iterative MDU.
// Signals: start, op[2:0], rs_val[31:0], rt_val[31:0] (master to slave);
//          busy, done, hi[31:0], lo[31:0] (slave to master).
interface mdu_iter_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers (32-step shift-add
// multiply, 32-step restoring divide, MTHI/MTLO writes).
// Ports: clk, rst (sync, active-high), bus (mdu_iter_if.slave).
// Optional divider: define MDU_DIV_EN to build the divide datapath.
module mdu_iter (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    // acc:lsw is the 64-bit product (mult) or remainder:quotient (div)
    logic [31:0] acc;
    logic [31:0] lsw;
    logic [31:0] mcand;
    logic        neg_lo;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_signed;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [32:0] mul_sum;
    logic [63:0] prod;
    logic [63:0] prod_fix;

    // MULT and DIV have op[0]=0; the others treat operands as unsigned
    assign is_signed = ~bus.op[0];
    assign rs_neg    = is_signed & bus.rs_val[31];
    assign rt_neg    = is_signed & bus.rt_val[31];
    assign rs_mag    = rs_neg ? (32'd0 - bus.rs_val) : bus.rs_val;
    assign rt_mag    = rt_neg ? (32'd0 - bus.rt_val) : bus.rt_val;

    assign mul_sum  = {1'b0, acc} + (lsw[0] ? {1'b0, mcand} : 33'd0);
    assign prod     = {acc, lsw};
    assign prod_fix = neg_lo ? (64'd0 - prod) : prod;

`ifdef MDU_DIV_EN
    logic        is_div;
    logic        neg_hi;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;

    // partial remainder is always below the divisor, so the low 32 bits
    // of the difference are exact whenever the subtract is taken
    assign div_shift = {acc, lsw[31]};
    assign div_ge    = div_shift >= {1'b0, mcand};
    assign div_diff  = div_shift[31:0] - mcand;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            acc    <= 32'd0;
            lsw    <= 32'd0;
            mcand  <= 32'd0;
            neg_lo <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
`ifdef MDU_DIV_EN
            is_div <= 1'b0;
            neg_hi <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                state  <= RUN;
                                cnt    <= 5'd0;
                                acc    <= 32'd0;
                                lsw    <= rt_mag;
                                mcand  <= rs_mag;
                                neg_lo <= rs_neg ^ rt_neg;
`ifdef MDU_DIV_EN
                                is_div <= 1'b0;
                                neg_hi <= 1'b0;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV_EN
                                state  <= RUN;
                                cnt    <= 5'd0;
                                acc    <= 32'd0;
                                lsw    <= rs_mag;
                                mcand  <= rt_mag;
                                is_div <= 1'b1;
                                // divide by zero keeps the all-ones quotient
                                neg_lo <= (rs_neg ^ rt_neg)
                                          & (bus.rt_val != 32'd0);
                                neg_hi <= rs_neg;
`else
                                done_q <= 1'b1;
`endif
                            end
                            OP_MTHI: begin
                                hi_q   <= bus.rs_val;
                                done_q <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_q   <= bus.rs_val;
                                done_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIN;
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        acc <= div_ge ? div_diff : div_shift[31:0];
                        lsw <= {lsw[30:0], div_ge};
                    end else begin
                        acc <= mul_sum[32:1];
                        lsw <= {mul_sum[0], lsw[31:1]};
                    end
`else
                    acc <= mul_sum[32:1];
                    lsw <= {mul_sum[0], lsw[31:1]};
`endif
                end
                FIN: begin
                    state  <= IDLE;
                    done_q <= 1'b1;
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        lo_q <= neg_lo ? (32'd0 - lsw) : lsw;
                        hi_q <= neg_hi ? (32'd0 - acc) : acc;
                    end else begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end
`else
                    hi_q <= prod_fix[63:32];
                    lo_q <= prod_fix[31:0];
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: cycle-level reference model plus
// directed vectors with literal expected HI/LO values.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_iter_if bus_if();

    mdu_iter dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // reference arithmetic straight from the instruction definitions
    task automatic calc(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] h,
                        output logic [31:0] l);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        h = 32'd0;
        l = 32'd0;
        case (o)
            3'b000: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                h = sp[63:32];
                l = sp[31:0];
            end
            3'b001: begin
                up = {32'd0, a} * {32'd0, b};
                h = up[63:32];
                l = up[31:0];
            end
            3'b010: begin
                sa = a;
                sb = b;
                if (b == 32'd0) begin
                    l = 32'hFFFFFFFF;
                    h = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    l = 32'h80000000;
                    h = 32'd0;
                end else begin
                    l = sa / sb;
                    h = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    l = 32'hFFFFFFFF;
                    h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endtask

    // model state: cycles left until HI/LO update, pending result
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    bit          armed = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            armed  = 1'b1;
            m_left = 0;
            m_done = 1'b0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
        end else if (m_left > 0) begin
            m_done = 1'b0;
            m_left--;
            if (m_left == 0) begin
                m_hi   = p_hi;
                m_lo   = p_lo;
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (bus_if.start) begin
                case (bus_if.op)
                    3'b000, 3'b001: begin
                        calc(bus_if.op, bus_if.rs_val, bus_if.rt_val,
                             p_hi, p_lo);
                        m_left = 33;
                    end
                    3'b010, 3'b011: begin
`ifdef MDU_DIV_EN
                        calc(bus_if.op, bus_if.rs_val, bus_if.rt_val,
                             p_hi, p_lo);
                        m_left = 33;
`else
                        m_done = 1'b1;
`endif
                    end
                    3'b100: begin
                        m_hi   = bus_if.rs_val;
                        m_done = 1'b1;
                    end
                    3'b101: begin
                        m_lo   = bus_if.rs_val;
                        m_done = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        #1;
        if (armed) begin
            chk("cyc_busy", {31'd0, bus_if.busy}, {31'd0, m_left > 0});
            chk("cyc_done", {31'd0, bus_if.done}, {31'd0, m_done});
            chk("cyc_hi", bus_if.hi, m_hi);
            chk("cyc_lo", bus_if.lo, m_lo);
        end
    end

    // called at a negedge; returns at the negedge after the accept edge,
    // with operands scrambled so late sampling would be caught
    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        bus_if.start  = 1'b1;
        bus_if.op     = o;
        bus_if.rs_val = a;
        bus_if.rt_val = b;
        @(negedge clk);
        bus_if.start  = 1'b0;
        bus_if.rs_val = ~a;
        bus_if.rt_val = ~b;
    endtask

    task automatic expect_hilo(input string nm, input logic [31:0] h,
                               input logic [31:0] l);
        chk({nm, "_hi"}, bus_if.hi, h);
        chk({nm, "_lo"}, bus_if.lo, l);
    endtask

    int bc;
    int dc;

    initial begin
        bus_if.start  = 1'b0;
        bus_if.op     = 3'b000;
        bus_if.rs_val = 32'd0;
        bus_if.rt_val = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        expect_hilo("reset", 32'd0, 32'd0);
        chk("reset_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("reset_done", {31'd0, bus_if.done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        bc = 0;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            bc += int'(bus_if.busy);
            dc += int'(bus_if.done);
            @(negedge clk);
        end
        chk("multu_busy_cycles", bc, 33);
        chk("multu_done_pulses", dc, 1);
        expect_hilo("multu_max", 32'hFFFFFFFE, 32'h00000001);

        issue(3'b000, 32'hFFFFFFFD, 32'h00000005);
        repeat (36) @(negedge clk);
        expect_hilo("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1);

        issue(3'b000, 32'h80000000, 32'h80000000);
        repeat (36) @(negedge clk);
        expect_hilo("mult_min", 32'h40000000, 32'h00000000);

        issue(3'b100, 32'h12345678, 32'h0);
        chk("mthi_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("mthi_done", {31'd0, bus_if.done}, 32'd1);
        expect_hilo("mthi", 32'h12345678, 32'h00000000);
        @(negedge clk);
        chk("mthi_done_end", {31'd0, bus_if.done}, 32'd0);

        issue(3'b101, 32'hCAFEF00D, 32'h0);
        expect_hilo("mtlo", 32'h12345678, 32'hCAFEF00D);
        @(negedge clk);

        issue(3'b110, 32'h55555555, 32'h1);
        chk("rsvd_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("rsvd_done", {31'd0, bus_if.done}, 32'd0);
        expect_hilo("rsvd", 32'h12345678, 32'hCAFEF00D);
        @(negedge clk);

`ifdef MDU_DIV_EN
        issue(3'b010, 32'hFFFFFFF9, 32'h00000002);
        repeat (36) @(negedge clk);
        expect_hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(3'b011, 32'h0000000A, 32'h00000000);
        repeat (36) @(negedge clk);
        expect_hilo("divu_zero", 32'h0000000A, 32'hFFFFFFFF);
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        repeat (36) @(negedge clk);
        expect_hilo("div_ovf", 32'h00000000, 32'h80000000);
        issue(3'b010, 32'h00000064, 32'hFFFFFFF9);
        repeat (36) @(negedge clk);
        expect_hilo("div_negdiv", 32'h00000002, 32'hFFFFFFF2);
        issue(3'b010, 32'hFFFFFFF9, 32'h00000000);
        repeat (36) @(negedge clk);
        expect_hilo("div_zero_s", 32'hFFFFFFF9, 32'hFFFFFFFF);
`else
        issue(3'b010, 32'h00000010, 32'h00000003);
        chk("div_off_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("div_off_done", {31'd0, bus_if.done}, 32'd1);
        expect_hilo("div_off", 32'h12345678, 32'hCAFEF00D);
        @(negedge clk);
`endif

        issue(3'b000, 32'h00000007, 32'h00000006);
        repeat (5) @(negedge clk);
        issue(3'b100, 32'hDEADBEEF, 32'h0);
        chk("ignored_busy", {31'd0, bus_if.busy}, 32'd1);
        repeat (30) @(negedge clk);
        expect_hilo("mult_ign", 32'h00000000, 32'h0000002A);

        issue(3'b001, 32'h00000005, 32'h00000005);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, bus_if.busy}, 32'd0);
        expect_hilo("abort", 32'd0, 32'd0);
        rst = 1'b0;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            dc += int'(bus_if.done);
            @(negedge clk);
        end
        chk("abort_no_done", dc, 0);

        issue(3'b001, 32'h00010000, 32'h00010000);
        repeat (36) @(negedge clk);
        expect_hilo("multu_fresh", 32'h00000001, 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
